// File: rtl/ata_dev_pkg.sv
// Shared constants and types for the ATA device-side port.
// Host/local register maps, Status bit positions and FSM states.
package ata_dev_pkg;

    localparam int DEPTH = 256;

    localparam logic [4:0] A_DATA   = 5'h00;
    localparam logic [4:0] A_ERR    = 5'h01;
    localparam logic [4:0] A_SECCNT = 5'h02;
    localparam logic [4:0] A_LBA0   = 5'h03;
    localparam logic [4:0] A_LBA1   = 5'h04;
    localparam logic [4:0] A_LBA2   = 5'h05;
    localparam logic [4:0] A_DEV    = 5'h06;
    localparam logic [4:0] A_STAT   = 5'h07;
    localparam logic [4:0] A_ALT    = 5'h0E;

    localparam logic [3:0] L_ERR    = 4'h1;
    localparam logic [3:0] L_SECCNT = 4'h2;
    localparam logic [3:0] L_LBA0   = 4'h3;
    localparam logic [3:0] L_LBA1   = 4'h4;
    localparam logic [3:0] L_LBA2   = 4'h5;
    localparam logic [3:0] L_DEV    = 4'h6;
    localparam logic [3:0] L_STAT   = 4'h7;
    localparam logic [3:0] L_CMD    = 4'h8;
    localparam logic [3:0] L_DEVCTL = 4'h9;
    localparam logic [3:0] L_PTR    = 4'hA;
    localparam logic [3:0] L_CTRL   = 4'hB;

    localparam int ST_BSY  = 7;
    localparam int ST_DRDY = 6;
    localparam int ST_DRQ  = 3;
    localparam int ST_ERR  = 0;

    localparam int DC_NIEN = 1;
    localparam int DC_SRST = 2;

    localparam logic [7:0] STATUS_RST  = 8'h50;
    localparam logic [7:0] STATUS_SRST = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_DRIVE,
        WR_CAPTURE,
        HOLD
    } ata_state_e;

endpackage

// File: rtl/ata_dpram_256x16.sv
// 256x16 true dual-port RAM, registered read on both ports.
// Port A faces the ATA host, port B the local CPU.
module ata_dpram_256x16
    import ata_dev_pkg::*;
(
    input  logic        clk,
    input  logic        en_a,
    input  logic        we_a,
    input  logic [7:0]  addr_a,
    input  logic [15:0] wdata_a,
    output logic [15:0] rdata_a,
    input  logic        en_b,
    input  logic        we_b,
    input  logic [7:0]  addr_b,
    input  logic [15:0] wdata_b,
    output logic [15:0] rdata_b
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            if (we_a) mem[addr_a] <= wdata_a;
            rdata_a <= mem[addr_a];
        end
        if (en_b) begin
            if (we_b) mem[addr_b] <= wdata_b;
            rdata_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/ata_device_port.sv
// ATA device-side responder: task-file registers, sector buffer,
// WAITN/INTRQ generation and a local Avalon-MM slave for firmware.
module ata_device_port
    import ata_dev_pkg::*;
(
    input  logic        csi_clockreset_clk,
    input  logic        csi_clockreset_reset_n,
    input  logic [4:0]  ATA_ADDR,
    input  logic        ATA_OEN,
    input  logic        ATA_WEN,
    inout  wire  [15:0] ATA_DATA,
    output logic        ATA_DATA_DIR,
    output logic        ATA_WAITN,
    output logic        ATA_INTRQ,
    input  logic [8:0]  avs_local_address,
    input  logic        avs_local_read,
    input  logic        avs_local_write,
    input  logic [15:0] avs_local_writedata,
    output logic [15:0] avs_local_readdata,
    output logic        ins_cmd_irq
);

    logic clk, rst_n;
    assign clk   = csi_clockreset_clk;
    assign rst_n = csi_clockreset_reset_n;

    logic        oen_s1, oen_s2, wen_s1, wen_s2;
    logic [4:0]  addr_s1, addr_s2;
    ata_state_e  state;
    logic [4:0]  h_addr;
    logic        rd_buf;
    logic [7:0]  rd_reg;
    logic [7:0]  error, features, seccnt, lba0, lba1, lba2, device;
    logic [7:0]  status, command, devctl, ptr;
    logic [7:0]  host_val, local_val;
    logic [15:0] q_a, q_b, l_rd_reg;
    logic        l_rd_buf;

    logic       host_rd, host_wr, data_go, l_buf, l_wr;
    logic [3:0] l_reg;
    logic [7:0] hd, lwd;

    assign host_rd = (state == RD_FETCH);
    assign host_wr = (state == WR_CAPTURE);
    assign data_go = (host_rd | host_wr) & (h_addr == A_DATA)
                   & status[ST_DRQ];
    assign hd      = ATA_DATA[7:0];
    assign l_buf   = avs_local_address[8];
    assign l_reg   = avs_local_address[3:0];
    assign l_wr    = avs_local_write & ~l_buf;
    assign lwd     = avs_local_writedata[7:0];

    assign ATA_DATA = ATA_DATA_DIR ? (rd_buf ? q_a : {8'h00, rd_reg})
                                   : 16'hzzzz;
    assign avs_local_readdata = l_rd_buf ? q_b : l_rd_reg;

    ata_dpram_256x16 u_ram (
        .clk     (clk),
        .en_a    (data_go),
        .we_a    (data_go & host_wr),
        .addr_a  (ptr),
        .wdata_a (ATA_DATA),
        .rdata_a (q_a),
        .en_b    (l_buf & (avs_local_read | avs_local_write)),
        .we_b    (l_buf & avs_local_write),
        .addr_b  (avs_local_address[7:0]),
        .wdata_b (avs_local_writedata),
        .rdata_b (q_b)
    );

    always_comb begin
        host_val = 8'h00;
        unique case (1'b1)
            h_addr == A_ERR:    host_val = error;
            h_addr == A_SECCNT: host_val = seccnt;
            h_addr == A_LBA0:   host_val = lba0;
            h_addr == A_LBA1:   host_val = lba1;
            h_addr == A_LBA2:   host_val = lba2;
            h_addr == A_DEV:    host_val = device;
            h_addr == A_STAT,
            h_addr == A_ALT:    host_val = status;
            default:            host_val = 8'h00;
        endcase
    end

    always_comb begin
        local_val = 8'h00;
        case (l_reg)
            L_ERR:    local_val = features;
            L_SECCNT: local_val = seccnt;
            L_LBA0:   local_val = lba0;
            L_LBA1:   local_val = lba1;
            L_LBA2:   local_val = lba2;
            L_DEV:    local_val = device;
            L_STAT:   local_val = status;
            L_CMD:    local_val = command;
            L_DEVCTL: local_val = devctl;
            L_PTR:    local_val = ptr;
            L_CTRL:   local_val = {7'd0, ins_cmd_irq};
            default:  local_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oen_s1  <= 1'b1;
            oen_s2  <= 1'b1;
            wen_s1  <= 1'b1;
            wen_s2  <= 1'b1;
            addr_s1 <= '0;
            addr_s2 <= '0;
        end else begin
            oen_s1  <= ATA_OEN;
            oen_s2  <= oen_s1;
            wen_s1  <= ATA_WEN;
            wen_s2  <= wen_s1;
            addr_s1 <= ATA_ADDR;
            addr_s2 <= addr_s1;
        end
    end

    // IDLE is only re-entered with both synced strobes high, so a low
    // level seen there is a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ATA_WAITN    <= 1'b1;
            ATA_DATA_DIR <= 1'b0;
            h_addr       <= '0;
            rd_buf       <= 1'b0;
            rd_reg       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ATA_WAITN <= ATA_OEN & ATA_WEN;
                    if (!oen_s2) begin
                        state     <= RD_FETCH;
                        h_addr    <= addr_s2;
                        ATA_WAITN <= 1'b0;
                    end else if (!wen_s2) begin
                        state     <= WR_CAPTURE;
                        h_addr    <= addr_s2;
                        ATA_WAITN <= 1'b0;
                    end
                end
                RD_FETCH: begin
                    rd_buf       <= data_go;
                    rd_reg       <= host_val;
                    ATA_DATA_DIR <= 1'b1;
                    ATA_WAITN    <= 1'b1;
                    state        <= RD_DRIVE;
                end
                RD_DRIVE: begin
                    if (oen_s2) begin
                        ATA_DATA_DIR <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_CAPTURE: begin
                    ATA_WAITN <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (wen_s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host updates are applied after local ones so the host wins a
    // same-cycle collision; a local ptr write still beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error       <= '0;
            features    <= '0;
            seccnt      <= '0;
            lba0        <= '0;
            lba1        <= '0;
            lba2        <= '0;
            device      <= '0;
            status      <= STATUS_RST;
            command     <= '0;
            devctl      <= '0;
            ptr         <= '0;
            ATA_INTRQ   <= 1'b0;
            ins_cmd_irq <= 1'b0;
        end else begin
            if (host_rd && h_addr == A_STAT) ATA_INTRQ <= 1'b0;
            if (data_go) ptr <= ptr + 8'd1;
            if (l_wr) begin
                case (l_reg)
                    L_ERR:    error  <= lwd;
                    L_SECCNT: seccnt <= lwd;
                    L_LBA0:   lba0   <= lwd;
                    L_LBA1:   lba1   <= lwd;
                    L_LBA2:   lba2   <= lwd;
                    L_DEV:    device <= lwd;
                    L_STAT: begin
                        status <= lwd;
                        if (!devctl[DC_NIEN]) ATA_INTRQ <= 1'b1;
                    end
                    L_PTR:    ptr <= lwd;
                    L_CTRL: begin
                        if (avs_local_writedata[0]) ins_cmd_irq <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (data_go && ptr == 8'hFF) status[ST_DRQ] <= 1'b0;
            if (host_wr) begin
                case (h_addr)
                    A_ERR:    features <= hd;
                    A_SECCNT: seccnt   <= hd;
                    A_LBA0:   lba0     <= hd;
                    A_LBA1:   lba1     <= hd;
                    A_LBA2:   lba2     <= hd;
                    A_DEV:    device   <= hd;
                    A_STAT: begin
                        command         <= hd;
                        status[ST_BSY]  <= 1'b1;
                        status[ST_DRQ]  <= 1'b0;
                        ins_cmd_irq     <= 1'b1;
                        ATA_INTRQ       <= 1'b0;
                    end
                    A_ALT: begin
                        devctl <= hd;
                        if (hd[DC_SRST]) begin
                            status    <= STATUS_SRST;
                            ptr       <= '0;
                            ATA_INTRQ <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_rd_buf <= 1'b0;
            l_rd_reg <= '0;
        end else if (avs_local_read) begin
            l_rd_buf <= l_buf;
            l_rd_reg <= {8'h00, local_val};
        end
    end

endmodule
